// File: rtl/dir_key_ctrl.sv
// Direction key front end: 2-flop sync + debounce for four buttons, press encoding,
// reversal/duplicate rejection and a 2-entry turn queue (enabled by `define DIR_QUEUE_EN).
module dir_key_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter logic [1:0]  INIT_DIR        = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       right,
  input  logic       left,
  input  logic [1:0] cur_dir,
  input  logic       step,
  output logic [1:0] next_direction,
  output logic       key_press,
  output logic [1:0] queue_cnt
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit index equals the direction code: UP=0, DOWN=1, RIGHT=2, LEFT=3.
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1, r_sync2, r_lvl, r_prev;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    w_evt;
  logic          w_any;
  logic [1:0]    w_code;
  logic          r_key_press;

  assign w_raw = {left, right, down, up};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_lvl   <= '0;
      r_prev  <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_lvl;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_lvl[i] <= ~r_lvl[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_evt = r_lvl & ~r_prev;
  assign w_any = |w_evt;

  always_comb begin
    w_code = 2'b00;
    if      (w_evt[0]) w_code = 2'b00;
    else if (w_evt[1]) w_code = 2'b01;
    else if (w_evt[2]) w_code = 2'b10;
    else if (w_evt[3]) w_code = 2'b11;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_key_press <= 1'b0;
    else      r_key_press <= w_any;
  end

  assign key_press = r_key_press;

`ifdef DIR_QUEUE_EN
  logic [1:0] r_q [2];
  logic       r_wp, r_rp;
  logic [1:0] r_qcnt, r_hold;
  logic [1:0] w_ref;
  logic       w_push, w_pop;

  // Reference is the last queued turn so consecutive turns are checked against each other.
  assign w_ref  = (r_qcnt != 2'd0) ? r_q[~r_wp] : cur_dir;
  assign w_push = w_any && (w_code != w_ref) && (w_code != (w_ref ^ 2'b01))
                  && ((r_qcnt != 2'd2) || step);
  assign w_pop  = step && (r_qcnt != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q[0] <= INIT_DIR;
      r_q[1] <= INIT_DIR;
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_qcnt <= 2'd0;
      r_hold <= INIT_DIR;
    end else begin
      if (w_push) begin
        r_q[r_wp] <= w_code;
        r_wp      <= ~r_wp;
      end
      if (w_pop) begin
        r_hold <= r_q[r_rp];
        r_rp   <= ~r_rp;
      end
      case ({w_push, w_pop})
        2'b10:   r_qcnt <= r_qcnt + 2'd1;
        2'b01:   r_qcnt <= r_qcnt - 2'd1;
        default: r_qcnt <= r_qcnt;
      endcase
    end
  end

  assign next_direction = (r_qcnt != 2'd0) ? r_q[r_rp] : r_hold;
  assign queue_cnt      = r_qcnt;
`else
  logic [1:0] r_pend, r_hold;
  logic       r_pend_vld;
  logic       w_acc;

  assign w_acc = w_any && (w_code != cur_dir) && (w_code != (cur_dir ^ 2'b01));

  // While no fresh turn is pending, hold_dir equals the pending register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend     <= INIT_DIR;
      r_hold     <= INIT_DIR;
      r_pend_vld <= 1'b0;
    end else begin
      if (step) r_hold <= r_pend;
      if (w_acc) begin
        r_pend     <= w_code;
        r_pend_vld <= 1'b1;
      end else if (step) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign next_direction = r_pend_vld ? r_pend : r_hold;
  assign queue_cnt      = 2'b00;
`endif

endmodule

// File: tb/tb_dir_key_ctrl.sv
// Directed bench for dir_key_ctrl with DEBOUNCE_CYCLES=4; expectations cover
// both the queued (DIR_QUEUE_EN) and single-pending builds.
module tb_dir_key_ctrl;

`ifdef DIR_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       up = 1'b0, down = 1'b0, right = 1'b0, left = 1'b0;
  logic [1:0] cur_dir = 2'b10;
  logic       step = 1'b0;
  logic [1:0] next_direction;
  logic       key_press;
  logic [1:0] queue_cnt;

  int n_vec = 0;
  int n_err = 0;

  dir_key_ctrl #(.DEBOUNCE_CYCLES(4), .INIT_DIR(2'b10)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .right(right), .left(left),
    .cur_dir(cur_dir), .step(step), .next_direction(next_direction),
    .key_press(key_press), .queue_cnt(queue_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_rst_nd"}, 8'(next_direction), 8'h2);
    chk({tag, "_rst_qc"}, 8'(queue_cnt), 8'h0);
    chk({tag, "_rst_kp"}, 8'(key_press), 8'h0);
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  // Raise buttons in mask {left,right,down,up}; key_press must appear exactly 7 edges later.
  task automatic press(input string tag, input logic [3:0] mask, input bit stp);
    int extra;
    {left, right, down, up} = mask;
    tick(6);
    chk({tag, "_kp_early"}, 8'(key_press), 8'h0);
    if (stp) step = 1'b1;
    tick(1);
    step = 1'b0;
    chk({tag, "_kp"}, 8'(key_press), 8'h1);
    tick(1);
    chk({tag, "_kp_late"}, 8'(key_press), 8'h0);
    {left, right, down, up} = 4'b0000;
    extra = 0;
    repeat (10) begin
      tick(1);
      if (key_press) extra++;
    end
    chk({tag, "_kp_release"}, 8'(extra), 8'h0);
  endtask

  task automatic do_step();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  initial begin
    int cnt;
    // 1: reset values and basic press latency
    tick(1);
    do_reset("t1");
    chk("t1_nd", 8'(next_direction), 8'h2);
    chk("t1_qc", 8'(queue_cnt), 8'h0);
    press("t1_up", 4'b0001, 1'b0);
    chk("t1_up_nd", 8'(next_direction), 8'h0);
    chk("t1_up_qc", 8'(queue_cnt), QEN ? 8'h1 : 8'h0);

    // 2: bounce never debounces
    do_reset("t2");
    cnt = 0;
    repeat (5) begin
      up = 1'b1;
      repeat (2) begin tick(1); if (key_press) cnt++; end
      up = 1'b0;
      repeat (2) begin tick(1); if (key_press) cnt++; end
    end
    repeat (10) begin tick(1); if (key_press) cnt++; end
    chk("t2_kp_count", 8'(cnt), 8'h0);
    chk("t2_qc", 8'(queue_cnt), 8'h0);
    chk("t2_nd", 8'(next_direction), 8'h2);

    // 3: reversal rejected, perpendicular accepted
    do_reset("t3");
    press("t3_left", 4'b1000, 1'b0);
    chk("t3_left_nd", 8'(next_direction), 8'h2);
    chk("t3_left_qc", 8'(queue_cnt), 8'h0);
    press("t3_down", 4'b0010, 1'b0);
    chk("t3_down_nd", 8'(next_direction), 8'h1);
    chk("t3_down_qc", 8'(queue_cnt), QEN ? 8'h1 : 8'h0);

    // 4: fill queue, drop when full, drain with steps
    do_reset("t4");
    press("t4_up", 4'b0001, 1'b0);
    press("t4_left", 4'b1000, 1'b0);
    chk("t4_full_qc", 8'(queue_cnt), QEN ? 8'h2 : 8'h0);
    chk("t4_full_nd", 8'(next_direction), 8'h0);
    press("t4_down", 4'b0010, 1'b0);
    chk("t4_drop_qc", 8'(queue_cnt), QEN ? 8'h2 : 8'h0);
    chk("t4_drop_nd", 8'(next_direction), QEN ? 8'h0 : 8'h1);
    do_step();
    chk("t4_s1_nd", 8'(next_direction), QEN ? 8'h3 : 8'h1);
    chk("t4_s1_qc", 8'(queue_cnt), QEN ? 8'h1 : 8'h0);
    do_step();
    chk("t4_s2_nd", 8'(next_direction), QEN ? 8'h3 : 8'h1);
    chk("t4_s2_qc", 8'(queue_cnt), 8'h0);

    // 5: step coinciding with an accepted push on a full queue
    do_reset("t5");
    press("t5_up", 4'b0001, 1'b0);
    press("t5_left", 4'b1000, 1'b0);
    press("t5_down", 4'b0010, 1'b1);
    chk("t5_qc", 8'(queue_cnt), QEN ? 8'h2 : 8'h0);
    chk("t5_nd", 8'(next_direction), QEN ? 8'h3 : 8'h1);
    do_step();
    chk("t5_s_nd", 8'(next_direction), 8'h1);
    chk("t5_s_qc", 8'(queue_cnt), QEN ? 8'h1 : 8'h0);

    // 6: simultaneous up+right gives one event (up), then async reset with full queue
    do_reset("t6");
    press("t6_upright", 4'b0101, 1'b0);
    chk("t6_pri_nd", 8'(next_direction), 8'h0);
    chk("t6_pri_qc", 8'(queue_cnt), QEN ? 8'h1 : 8'h0);
    press("t6_left", 4'b1000, 1'b0);
    chk("t6_full_qc", 8'(queue_cnt), QEN ? 8'h2 : 8'h0);
    chk("t6_full_nd", 8'(next_direction), 8'h0);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_async_qc", 8'(queue_cnt), 8'h0);
    chk("t6_async_nd", 8'(next_direction), 8'h2);
    chk("t6_async_kp", 8'(key_press), 8'h0);
    tick(2);
    rst = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
